// File: rtl/p_element.sv
// Output-stationary systolic MAC tile: accumulates in_N*in_W every cycle
// and forwards both operands, registered, to the south and east.
module p_element #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  output logic [ACC_W-1:0]  out,
  output logic [DATA_W-1:0] out_S,
  output logic [DATA_W-1:0] out_E,
  input  logic [DATA_W-1:0] in_N,
  input  logic [DATA_W-1:0] in_W,
  input  logic              clk,
  input  logic              reset
);

  localparam int PW = 2 * DATA_W;

  localparam logic [ACC_W-1:0] U_MAX = '1;
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] reg_s;
  logic [DATA_W-1:0] reg_e;

  logic signed [PW-1:0] prod_s;
  logic        [PW-1:0] prod_u;
  logic [ACC_W-1:0]     prod_ext;
  logic [ACC_W:0]       sum;
  logic                 ovf_u;
  logic                 ovf_s;
  logic [ACC_W-1:0]     acc_nx;

  always_comb begin
    prod_s   = $signed(in_N) * $signed(in_W);
    prod_u   = in_N * in_W;
    prod_ext = (SIGNED != 0) ? ACC_W'(prod_s) : ACC_W'(prod_u);
    sum      = {1'b0, acc} + {1'b0, prod_ext};
    ovf_u    = sum[ACC_W];
    // Signed overflow: addends agree in sign but the result does not.
    ovf_s    = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum[ACC_W-1] != acc[ACC_W-1]);
    acc_nx   = sum[ACC_W-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (ovf_s) acc_nx = acc[ACC_W-1] ? S_MIN : S_MAX;
      end else begin
        if (ovf_u) acc_nx = U_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      reg_s <= '0;
      reg_e <= '0;
    end else begin
      acc   <= acc_nx;
      reg_s <= in_N;
      reg_e <= in_W;
    end
  end

  assign out   = acc;
  assign out_S = reg_s;
  assign out_E = reg_e;

endmodule

// File: tb/tb_p_element.sv
// Bench for p_element: four parameter variants share one stimulus stream
// and are checked against an arithmetic reference model.
module tb_p_element;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_N;
  logic [15:0] in_W;

  logic [31:0] out_v [4];
  logic [15:0] s_v   [4];
  logic [15:0] e_v   [4];

  int     n_chk = 0;
  int     n_err = 0;
  longint m_acc [4];
  logic [15:0] m_s;
  logic [15:0] m_e;

  always #5 clk = ~clk;

  // Instance k: SIGNED = k/2, SATURATE = k%2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    p_element #(
      .DATA_W(16), .ACC_W(32), .SIGNED(g / 2), .SATURATE(g % 2)
    ) u_dut (
      .out(out_v[g]), .out_S(s_v[g]), .out_E(e_v[g]),
      .in_N(in_N), .in_W(in_W), .clk(clk), .reset(reset)
    );
  end

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint mac(input int k, input longint a,
                                 input logic [15:0] n,
                                 input logic [15:0] w);
    longint p, s;
    bit sg, sat;
    sg  = (k >= 2);
    sat = (k % 2) == 1;
    if (sg) p = longint'($signed(n)) * longint'($signed(w));
    else    p = longint'(n) * longint'(w);
    s = a + p;
    if (sg) begin
      if (sat) begin
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
      end else begin
        s = longint'($signed(s[31:0]));
      end
    end else begin
      if (sat && s > 64'sd4294967295) s = 64'sd4294967295;
      else s = s & 64'hFFFF_FFFF;
    end
    return s;
  endfunction

  task automatic step(input logic [15:0] n, input logic [15:0] w,
                      input logic r);
    in_N  = n;
    in_W  = w;
    reset = r;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      m_acc[k] = r ? 64'sd0 : mac(k, m_acc[k], n, w);
    m_s = r ? 16'h0 : n;
    m_e = r ? 16'h0 : w;
  endtask

  task automatic check_all(input string tag);
    longint lo;
    for (int k = 0; k < 4; k++) begin
      lo = m_acc[k] & 64'hFFFF_FFFF;
      check($sformatf("%s_out%0d", tag, k), longint'(out_v[k]), lo);
      check($sformatf("%s_s%0d", tag, k), longint'(s_v[k]), longint'(m_s));
      check($sformatf("%s_e%0d", tag, k), longint'(e_v[k]), longint'(m_e));
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) m_acc[k] = 0;
    m_s = '0;
    m_e = '0;

    // Reset overrides live operands
    step(16'd7, 16'd9, 1'b1);
    check("rst_out", longint'(out_v[0]), 0);
    check("rst_s", longint'(s_v[0]), 0);
    check("rst_e", longint'(e_v[0]), 0);
    check_all("rst");

    // Basic MAC
    step(16'd1, 16'd2, 1'b0);
    check("mac1", longint'(out_v[0]), 2);
    check("mac1_s", longint'(s_v[0]), 1);
    check("mac1_e", longint'(e_v[0]), 2);
    step(16'd3, 16'd4, 1'b0);
    check("mac2", longint'(out_v[0]), 14);
    step(16'd5, 16'd6, 1'b0);
    check("mac3", longint'(out_v[0]), 44);
    check("mac3_s", longint'(s_v[0]), 5);
    step(16'd5, 16'd6, 1'b0);
    check("mac4", longint'(out_v[0]), 74);
    check_all("mac");

    // Mid-stream reset discards the product of that cycle
    step(16'd0, 16'd0, 1'b1);
    step(16'd1, 16'd2, 1'b0);
    step(16'd3, 16'd4, 1'b0);
    step(16'd5, 16'd6, 1'b1);
    check("midrst", longint'(out_v[0]), 0);
    check("midrst_e", longint'(e_v[0]), 0);
    step(16'd5, 16'd6, 1'b0);
    check("after_rst", longint'(out_v[0]), 30);
    check_all("midrst");

    // Zero operand contributes nothing
    step(16'd0, 16'd0, 1'b1);
    step(16'd1, 16'd2, 1'b0);
    step(16'd3, 16'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(16'd0, 16'd1234, 1'b0);
      check("zero_out", longint'(out_v[0]), 14);
      check("zero_e", longint'(e_v[0]), 1234);
    end

    // Signed operands
    step(16'd0, 16'd0, 1'b1);
    step(16'hFFFD, 16'd4, 1'b0);
    check("sgn1", longint'(out_v[2]), 64'hFFFF_FFF4);
    check("sgn1_s", longint'(s_v[2]), 64'hFFFD);
    step(16'd2, 16'd5, 1'b0);
    check("sgn2", longint'(out_v[2]), 64'hFFFF_FFFE);
    check("sgn2_s", longint'(s_v[2]), 2);
    check_all("sgn");

    // Unsigned wrap vs saturate
    step(16'd0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(16'hFFFF, 16'hFFFF, 1'b0);
    check("wrap", longint'(out_v[0]), 64'hFFFA_0003);
    check("usat", longint'(out_v[1]), 64'hFFFF_FFFF);
    step(16'hFFFF, 16'hFFFF, 1'b0);
    check("usat_hold", longint'(out_v[1]), 64'hFFFF_FFFF);
    check_all("usat");

    // Signed saturation at both limits
    step(16'd0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(16'h8000, 16'h8000, 1'b0);
    check("ssat_max", longint'(out_v[3]), 64'h7FFF_FFFF);
    check_all("ssat_hi");
    step(16'd0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(16'h8000, 16'h7FFF, 1'b0);
    check("ssat_min", longint'(out_v[3]), 64'h8000_0000);
    check_all("ssat_lo");

    // Random stream with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(pick(), pick(), $urandom_range(0, 19) == 0);
      check_all("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
